// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions: frame geometry, sync header bytes and the
// readout scheduler state type. The pixel packer imports FRAME_BYTES from here too.
package fb_pkg;

  localparam int FRAME_BYTES = 5100;
  localparam int FB_ADDR_W   = $clog2(FRAME_BYTES);

  localparam logic [7:0] SYNC0 = 8'hA5;
  localparam logic [7:0] SYNC1 = 8'h5A;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    HDR0,
    HDR1,
    FETCH,
    LATCH,
    SEND,
    DONE
  } fb_state_t;

  // Banks may only swap while no readout owns the read bank.
  function automatic logic banks_locked(input fb_state_t s);
    return !((s == IDLE) || (s == ARM));
  endfunction

endpackage

// File: rtl/fb_bank_ctrl.sv
// Ping-pong bank ownership: swaps banks on unlocked frame ticks and counts
// frames the packer completed while a readout held the banks (saturating).
module fb_bank_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       lock,
  input  logic       arm,
  output logic       wr_bank,
  output logic       rd_bank,
  output logic       swap,
  output logic       start,
  output logic [7:0] drop_cnt
);

  assign swap  = tick && !lock;
  assign start = swap && arm;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b1;
      drop_cnt <= 8'd0;
    end else if (swap) begin
      wr_bank <= ~wr_bank;
      rd_bank <= wr_bank;
    end else if (tick && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/frame_buf_tx_scheduler.sv
// Streams the completed frame-buffer bank to the UART TX on host request.
// Define FRAME_HDR_EN to prefix each frame with the sync bytes A5,5A.
//
// state | meaning
// IDLE  | waiting for start_req; frame ticks still swap banks
// ARM   | start accepted, waiting for the next completed frame
// HDR0  | offering sync byte A5 (FRAME_HDR_EN only)
// HDR1  | offering sync byte 5A (FRAME_HDR_EN only)
// FETCH | BRAM read issued for addr
// LATCH | read data captured into tx_data
// SEND  | payload byte offered to the UART
// DONE  | one-cycle done pulse, then back to IDLE
module frame_buf_tx_scheduler
  import fb_pkg::*;
#(
  parameter int FRAME_BYTES = fb_pkg::FRAME_BYTES,
  parameter int ADDR_W      = $clog2(FRAME_BYTES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_frame_tick,
  input  logic              start_req,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic [7:0]        drop_cnt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BYTES - 1);

  fb_state_t         state;
  logic [ADDR_W-1:0] addr;
  logic              swap;
  logic              start;

  fb_bank_ctrl u_bank_ctrl (
    .clk      (clk),
    .reset    (reset),
    .tick     (wr_frame_tick),
    .lock     (banks_locked(state)),
    .arm      (state == ARM),
    .wr_bank  (wr_bank),
    .rd_bank  (rd_bank),
    .swap     (swap),
    .start    (start),
    .drop_cnt (drop_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      addr     <= '0;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      tx_data  <= 8'd0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      rd_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          // A tick arriving with start_req swaps here but is not the frame we send.
          if (start_req) begin
            busy  <= 1'b1;
            state <= ARM;
          end
        end
        ARM: begin
          if (start) begin
            addr <= '0;
`ifdef FRAME_HDR_EN
            tx_data  <= SYNC0;
            tx_valid <= 1'b1;
            state    <= HDR0;
`else
            rd_en   <= 1'b1;
            rd_addr <= '0;
            state   <= FETCH;
`endif
          end
        end
`ifdef FRAME_HDR_EN
        HDR0: begin
          if (tx_ready) begin
            tx_data <= SYNC1;
            state   <= HDR1;
          end
        end
        HDR1: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            rd_en    <= 1'b1;
            rd_addr  <= addr;
            state    <= FETCH;
          end
        end
`endif
        FETCH: state <= LATCH;
        LATCH: begin
          tx_data  <= rd_data;
          tx_valid <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (addr == LAST_ADDR) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              addr    <= addr + 1'b1;
              rd_en   <= 1'b1;
              rd_addr <= addr + 1'b1;
              state   <= FETCH;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buf_tx_scheduler.sv
// Bench for frame_buf_tx_scheduler: BRAM model, byte-stream reference model,
// directed scenario sequence with randomized tx_ready back-pressure.
module tb_frame_buf_tx_scheduler;
  import fb_pkg::*;

  localparam int N = FRAME_BYTES;
`ifdef FRAME_HDR_EN
  localparam int HDR = 2;
`else
  localparam int HDR = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_frame_tick = 1'b0;
  logic        start_req = 1'b0;
  logic        tx_ready = 1'b0;
  logic [7:0]  rd_data = 8'd0;
  logic        wr_bank, rd_bank, rd_en, tx_valid, busy, done;
  logic [12:0] rd_addr;
  logic [7:0]  tx_data, drop_cnt;

  int total = 0;
  int passed = 0;
  int failed = 0;
  int cyc = 0;
  int stab_err = 0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_data = 8'd0;
  logic [7:0] got[$];
  logic [7:0] mem[2][N];
  bit exp_wr = 1'b0;

  frame_buf_tx_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .wr_frame_tick (wr_frame_tick),
    .start_req     (start_req),
    .wr_bank       (wr_bank),
    .rd_bank       (rd_bank),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .busy          (busy),
    .done          (done),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 1-cycle latency BRAM read port
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_bank][int'(rd_addr)];

  // Transfer capture and hold-while-stalled monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !(tx_valid === 1'b1 && tx_data === prev_data)) stab_err++;
      if (tx_valid && tx_ready) got.push_back(tx_data);
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  function automatic logic [7:0] bank_byte(input int i, input bit bank);
    return 8'(i) ^ (bank ? 8'h3C : 8'h00);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input bit rnd, input int drops, input bit dup, input int abort_at);
    bit seen;
    int done_cyc;
    int tick_cyc;
    bit rbank;
    int bad;
    logic [7:0] exp_q[$];
    seen = 1'b0;
    done_cyc = 0;
    got.delete();
    stab_err = 0;
    tx_ready = 1'b1;
    start_req = 1'b1;
    step;
    start_req = 1'b0;
    check("busy_after_start", busy, 1);
    repeat (10) step;
    check("arm_tx_valid", tx_valid, 0);
    check("arm_no_bytes", got.size(), 0);
    wr_frame_tick = 1'b1;
    step;
    wr_frame_tick = 1'b0;
    tick_cyc = cyc;
    exp_wr = !exp_wr;
    rbank = !exp_wr;
    check("arm_tick_swaps", wr_bank, exp_wr);
    for (int c = 0; c < 45000; c++) begin
      if (abort_at > 0 && got.size() >= abort_at) break;
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_frame_tick = (c >= 1000) && (c < 1000 + 37 * drops) && ((c - 1000) % 37 == 0);
      start_req = dup && (c == 500);
      step;
      if (done) begin
        seen = 1'b1;
        done_cyc = cyc;
        break;
      end
    end
    wr_frame_tick = 1'b0;
    start_req = 1'b0;
    tx_ready = 1'b1;
    if (abort_at > 0) begin
      check("abort_point_reached", got.size() >= abort_at, 1);
      check("no_done_before_abort", seen, 0);
      reset = 1'b1;
      step;
      reset = 1'b0;
      check("abort_tx_valid", tx_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_drop_cnt", drop_cnt, 0);
      check("abort_wr_bank", wr_bank, 0);
      exp_wr = 1'b0;
      return;
    end
    check("done_seen", seen, 1);
    check("busy_at_done", busy, 1);
    if (!rnd) check("frame_latency", done_cyc - tick_cyc, 3 * N + HDR);
`ifdef FRAME_HDR_EN
    exp_q.push_back(SYNC0);
    exp_q.push_back(SYNC1);
`endif
    for (int i = 0; i < N; i++) exp_q.push_back(bank_byte(i, rbank));
    check("byte_count", got.size(), exp_q.size());
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      if (got[i] !== exp_q[i]) bad++;
    check("byte_errors", bad, 0);
    check("stable_while_stalled", stab_err, 0);
    step;
    check("busy_after_done", busy, 0);
    check("done_one_cycle", done, 0);
    check("wr_bank_after_frame", wr_bank, exp_wr);
    check("rd_bank_after_frame", rd_bank, !exp_wr);
    if (dup) begin
      repeat (30) step;
      check("single_frame_bytes", got.size(), exp_q.size());
      check("idle_after_dup_start", busy, 0);
    end
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < N; i++) mem[b][i] = bank_byte(i, b[0]);

    reset = 1'b1;
    repeat (3) step;
    check("rst_wr_bank", wr_bank, 0);
    check("rst_rd_bank", rd_bank, 1);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    reset = 1'b0;
    step;

    wr_frame_tick = 1'b1;
    step;
    wr_frame_tick = 1'b0;
    exp_wr = 1'b1;
    check("idle_tick_wr_bank", wr_bank, 1);
    check("idle_tick_rd_bank", rd_bank, 0);
    check("idle_tick_busy", busy, 0);
    check("idle_tick_tx_valid", tx_valid, 0);
    repeat (5) step;
    check("idle_tick_no_bytes", got.size(), 0);
    check("idle_tick_no_drop", drop_cnt, 0);

    run_frame(1'b0, 3, 1'b1, 0);
    check("drop_cnt_3", drop_cnt, 3);

    run_frame(1'b1, 300, 1'b0, 0);
    check("drop_cnt_saturated", drop_cnt, 255);

    run_frame(1'b0, 0, 1'b0, 2000);
    repeat (3) step;

    run_frame(1'b0, 0, 1'b0, 0);
    check("drop_cnt_after_clean_frame", drop_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
